// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing and board-grid constants.
// Imported by the sync generator and the renderers.
package vga_pkg;

    localparam int CW = 10;

    localparam int H_ATIVO  = 640;
    localparam int H_FRENTE = 16;
    localparam int H_SYNC   = 96;
    localparam int H_TRAS   = 48;
    localparam int V_ATIVO  = 480;
    localparam int V_FRENTE = 10;
    localparam int V_SYNC   = 2;
    localparam int V_TRAS   = 33;

    localparam int H_TOTAL =
        H_ATIVO + H_FRENTE + H_SYNC + H_TRAS;
    localparam int V_TOTAL =
        V_ATIVO + V_FRENTE + V_SYNC + V_TRAS;

    // Board grid geometry used by the renderers
    localparam int CEL_LARG     = 54;
    localparam int CEL_ALT      = 49;
    localparam int GRADE_ORIGEM = 16;
    localparam int PASSO_X      = 62;
    localparam int PASSO_Y      = 57;

endpackage

// File: rtl/vga_sincronizador_if.sv
// Timing bundle from the sync generator to the renderers
// and the board connector.
interface vga_sincronizador_if;
    import vga_pkg::*;

    logic [CW-1:0] linha;
    logic [CW-1:0] coluna;
    logic          areaAtiva;
    logic          hsync;
    logic          vsync;
    logic          inicioQuadro;

    modport master (
        output linha, coluna, areaAtiva,
        output hsync, vsync, inicioQuadro
    );

    modport slave (
        input linha, coluna, areaAtiva,
        input hsync, vsync, inicioQuadro
    );

endinterface

// File: rtl/vga_sincronizador_contador.sv
// Modulo-N counter with enable, reset to N-1 and terminal count.
// o_prox exposes the value the counter takes on the next edge.
module vga_contador
    import vga_pkg::*;
#(
    parameter int N = 800
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_en,
    output logic [CW-1:0] o_cnt,
    output logic [CW-1:0] o_prox,
    output logic          o_tc
);

    localparam logic [CW-1:0] MAX = CW'(N - 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_prox;
    logic          w_tc;

    always_comb begin
        w_tc   = (r_cnt == MAX);
        w_prox = r_cnt;
        if (i_en)
            w_prox = w_tc ? '0 : r_cnt + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= MAX;
        else
            r_cnt <= w_prox;
    end

    assign o_cnt  = r_cnt;
    assign o_prox = w_prox;
    assign o_tc   = w_tc;

endmodule

// File: rtl/vga_sincronizador.sv
// VGA 640x480@60 timing generator with registered, aligned decodes.
// Optional macro VGA_SINCRONIZADOR_DIV2_EN: pixel enable on every 2nd clk.
module vga_sincronizador #(
    parameter int H_ATIVO  = vga_pkg::H_ATIVO,
    parameter int H_FRENTE = vga_pkg::H_FRENTE,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_TRAS   = vga_pkg::H_TRAS,
    parameter int V_ATIVO  = vga_pkg::V_ATIVO,
    parameter int V_FRENTE = vga_pkg::V_FRENTE,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_TRAS   = vga_pkg::V_TRAS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    vga_sincronizador_if.master   o_vga
);
    import vga_pkg::*;

    localparam int HT = H_ATIVO + H_FRENTE + H_SYNC + H_TRAS;
    localparam int VT = V_ATIVO + V_FRENTE + V_SYNC + V_TRAS;

    localparam logic [CW-1:0] HA  = CW'(H_ATIVO);
    localparam logic [CW-1:0] VA  = CW'(V_ATIVO);
    localparam logic [CW-1:0] HSI = CW'(H_ATIVO + H_FRENTE);
    localparam logic [CW-1:0] HSF = CW'(H_ATIVO + H_FRENTE + H_SYNC - 1);
    localparam logic [CW-1:0] VSI = CW'(V_ATIVO + V_FRENTE);
    localparam logic [CW-1:0] VSF = CW'(V_ATIVO + V_FRENTE + V_SYNC - 1);

    logic          w_pe;
    logic          w_ven;
    logic [CW-1:0] w_h;
    logic [CW-1:0] w_v;
    logic [CW-1:0] w_hprox;
    logic [CW-1:0] w_vprox;
    logic          w_htc;
    logic          w_vtc;

    logic          r_area;
    logic          r_hs;
    logic          r_vs;
    logic          r_ini;

`ifdef VGA_SINCRONIZADOR_DIV2_EN
    logic r_div;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_div <= 1'b0;
        else
            r_div <= !r_div;
    end

    assign w_pe = r_div;
`else
    assign w_pe = 1'b1;
`endif

    assign w_ven = w_pe & w_htc;

    vga_contador #(.N(HT)) u_h (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (w_pe),
        .o_cnt  (w_h),
        .o_prox (w_hprox),
        .o_tc   (w_htc)
    );

    vga_contador #(.N(VT)) u_v (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (w_ven),
        .o_cnt  (w_v),
        .o_prox (w_vprox),
        .o_tc   (w_vtc)
    );

    // Decoding next-state keeps flags aligned with linha/coluna
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_area <= 1'b0;
            r_hs   <= 1'b1;
            r_vs   <= 1'b1;
            r_ini  <= 1'b0;
        end else begin
            r_area <= (w_hprox < HA) && (w_vprox < VA);
            r_hs   <= !((w_hprox >= HSI) && (w_hprox <= HSF));
            r_vs   <= !((w_vprox >= VSI) && (w_vprox <= VSF));
            r_ini  <= w_ven & w_vtc;
        end
    end

    assign o_vga.linha        = w_h;
    assign o_vga.coluna       = w_v;
    assign o_vga.areaAtiva    = r_area;
    assign o_vga.hsync        = r_hs;
    assign o_vga.vsync        = r_vs;
    assign o_vga.inicioQuadro = r_ini;

endmodule

// File: tb/tb_vga_sincronizador.sv
// Directed bench for vga_sincronizador: full-size and reduced-timing
// instances checked step by step against hand-derived positions.
module tb_vga_sincronizador;

`ifdef VGA_SINCRONIZADOR_DIV2_EN
    localparam int K = 2;
`else
    localparam int K = 1;
`endif

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

    vga_sincronizador_if ia ();
    vga_sincronizador_if ib ();

    vga_sincronizador u_a (
        .clk   (clk),
        .rst_n (rst_a),
        .o_vga (ia)
    );

    // Small frame: 15 x 8, hsync at h 10..12, vsync at v 5..6
    vga_sincronizador #(
        .H_ATIVO(8), .H_FRENTE(2), .H_SYNC(3), .H_TRAS(2),
        .V_ATIVO(4), .V_FRENTE(1), .V_SYNC(2), .V_TRAS(1)
    ) u_b (
        .clk   (clk),
        .rst_n (rst_b),
        .o_vga (ib)
    );

    int n_chk = 0;
    int n_err = 0;

    int ah = 799, av = 524, aini = 0;
    int bh = 14,  bv = 7,   bini = 0;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_pos(input string p,
                           input int h, input int v, input int ini,
                           input int ha, input int hf, input int hs,
                           input int va, input int vf, input int vs,
                           input logic [9:0] l, input logic [9:0] c,
                           input logic o_ar, input logic o_hs,
                           input logic o_vs, input logic o_iq);
        int e_ar, e_hs, e_vs;
        e_ar = (h < ha && v < va) ? 1 : 0;
        e_hs = (h >= ha + hf && h < ha + hf + hs) ? 0 : 1;
        e_vs = (v >= va + vf && v < va + vf + vs) ? 0 : 1;
        chk({p, "_linha"},  {22'd0, l}, h);
        chk({p, "_coluna"}, {22'd0, c}, v);
        chk({p, "_area"},   {31'd0, o_ar}, e_ar);
        chk({p, "_hsync"},  {31'd0, o_hs}, e_hs);
        chk({p, "_vsync"},  {31'd0, o_vs}, e_vs);
        chk({p, "_inicio"}, {31'd0, o_iq}, ini);
    endtask

    task automatic adv(inout int h, inout int v, output int ini,
                       input logic run, input int ht, input int vt);
        ini = 0;
        if (run) begin
            if (h == ht - 1) begin
                h = 0;
                v = (v == vt - 1) ? 0 : v + 1;
            end else begin
                h++;
            end
            ini = (h == 0 && v == 0) ? 1 : 0;
        end
    endtask

    task automatic chk_a(input int ini);
        chk_pos("a", ah, av, ini, 640, 16, 96, 480, 10, 2,
                ia.linha, ia.coluna, ia.areaAtiva,
                ia.hsync, ia.vsync, ia.inicioQuadro);
    endtask

    task automatic chk_b(input int ini);
        chk_pos("b", bh, bv, ini, 8, 2, 3, 4, 1, 2,
                ib.linha, ib.coluna, ib.areaAtiva,
                ib.hsync, ib.vsync, ib.inicioQuadro);
    endtask

    task automatic step();
        repeat (K) @(posedge clk);
        #1;
        adv(ah, av, aini, rst_a, 800, 525);
        adv(bh, bv, bini, rst_b, 15, 8);
        chk_a(aini);
        chk_b(bini);
    endtask

    int a_area = 0, a_hslow = 0, a_fall = -1, a_rise = -1;
    logic a_prev_hs = 1'b1;
    int prev_l = -1, prev_c = -1;
    int prev_bl = -1, prev_bc = -1;
    int b_vslow = 0, b_nini = 0, b_last = -1;
    bit hit;

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk_a(0);
        chk_b(0);

        rst_a = 1'b1;
        rst_b = 1'b1;

        for (int i = 0; i < 1700; i++) begin
            step();
            if (i == 0) begin
                chk("first_ini", {31'd0, ia.inicioQuadro}, 1);
                chk("first_area", {31'd0, ia.areaAtiva}, 1);
`ifdef VGA_SINCRONIZADOR_DIV2_EN
                @(posedge clk);
                #1;
                chk_a(0);
                chk_b(0);
                chk("div_ini_1clk", {31'd0, ia.inicioQuadro}, 0);
                @(posedge clk);
                #1;
                adv(ah, av, aini, rst_a, 800, 525);
                adv(bh, bv, bini, rst_b, 15, 8);
                chk_a(aini);
                chk_b(bini);
                chk("div_adv", {22'd0, ia.linha}, 1);
`endif
            end
            if (i < 800) begin
                a_area  += int'(ia.areaAtiva);
                a_hslow += int'(!ia.hsync);
                if (!ia.hsync && a_prev_hs) a_fall = int'(ia.linha);
                if (ia.hsync && !a_prev_hs) a_rise = int'(ia.linha);
                a_prev_hs = ia.hsync;
            end
            if (prev_l == 799) begin
                chk("wrap_h", {22'd0, ia.linha}, 0);
                chk("wrap_v", {22'd0, ia.coluna}, prev_c + 1);
            end
            prev_l = int'(ia.linha);
            prev_c = int'(ia.coluna);
            if (prev_bl == 14 && prev_bc == 7) begin
                chk("b_wrap_h", {22'd0, ib.linha}, 0);
                chk("b_wrap_v", {22'd0, ib.coluna}, 0);
            end
            prev_bl = int'(ib.linha);
            prev_bc = int'(ib.coluna);
            if (i < 120) b_vslow += int'(!ib.vsync);
            if (ib.inicioQuadro) begin
                if (b_last >= 0) chk("b_ini_period", i - b_last, 120);
                b_last = i;
                b_nini++;
            end
        end

        chk("a_area_cnt", a_area, 640);
        chk("a_hs_low_cnt", a_hslow, 96);
        chk("a_hs_fall", a_fall, 656);
        chk("a_hs_rise", a_rise, 752);
        chk("b_vs_low_cnt", b_vslow, 30);
        chk("b_ini_cnt", b_nini, 15);

        hit = 1'b0;
        for (int j = 0; j < 820; j++) begin
            if (ah == 700) begin
                hit = 1'b1;
                break;
            end
            step();
        end
        chk("reach_a700", {31'd0, hit}, 1);
        chk("a_hs_pre", {31'd0, ia.hsync}, 0);
        #1 rst_a = 1'b0;
        #1;
        ah = 799;
        av = 524;
        chk_a(0);

        hit = 1'b0;
        for (int j = 0; j < 150; j++) begin
            if (bh == 10 && bv == 5) begin
                hit = 1'b1;
                break;
            end
            step();
        end
        chk("reach_b_vs", {31'd0, hit}, 1);
        chk("b_vs_pre", {31'd0, ib.vsync}, 0);
        #1 rst_b = 1'b0;
        #1;
        bh = 14;
        bv = 7;
        chk_b(0);

        rst_a = 1'b1;
        rst_b = 1'b1;
        step();
        chk("rst2_ini_a", {31'd0, ia.inicioQuadro}, 1);
        chk("rst2_ini_b", {31'd0, ib.inicioQuadro}, 1);
        for (int j = 0; j < 30; j++) step();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
